// File: rtl/cdb_reservation_station.sv
// Reservation station: holds dispatched ops until both operands arrive over the CDB,
// then presents the lowest-index ready entry to a functional unit under valid/ready.
module cdb_reservation_station #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  parameter int OP_W  = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              FLUSH,
  input  logic              DISP_VALID,
  output logic              DISP_READY,
  input  logic [OP_W-1:0]   DISP_OP,
  input  logic [TAG_W-1:0]  DISP_DEST_TAG,
  input  logic [TAG_W-1:0]  DISP_QJ,
  input  logic [TAG_W-1:0]  DISP_QK,
  input  logic [31:0]       DISP_VJ,
  input  logic [31:0]       DISP_VK,
  input  logic [TAG_W+31:0] CDB_IN,
  output logic              ISSUE_VALID,
  input  logic              ISSUE_READY,
  output logic [OP_W-1:0]   ISSUE_OP,
  output logic [TAG_W-1:0]  ISSUE_DEST_TAG,
  output logic [31:0]       ISSUE_VJ,
  output logic [31:0]       ISSUE_VK,
  output logic [2:0]        COUNT
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Handshakes: dispatch fires on DISP_VALID && DISP_READY && !FLUSH;
  // issue fires on ISSUE_VALID && ISSUE_READY. A stalled presentation locks its entry.
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [OP_W-1:0]  op_q[DEPTH], op_d[DEPTH];
  logic [TAG_W-1:0] dest_q[DEPTH], dest_d[DEPTH];
  logic [TAG_W-1:0] qj_q[DEPTH], qj_d[DEPTH];
  logic [TAG_W-1:0] qk_q[DEPTH], qk_d[DEPTH];
  logic [31:0]      vj_q[DEPTH], vj_d[DEPTH];
  logic [31:0]      vk_q[DEPTH], vk_d[DEPTH];
  logic             lock_q, lock_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic [2:0]       count_q, count_d;

  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;
  logic             cdb_hit;
  logic [DEPTH-1:0] ready;
  logic             free_found, ready_found;
  logic [IDX_W-1:0] free_idx, ready_idx, sel_idx;
  logic             disp_fire, issue_fire;

  assign cdb_tag  = CDB_IN[TAG_W+31:32];
  assign cdb_data = CDB_IN[31:0];
  assign cdb_hit  = (cdb_tag != '0);

  always_comb begin
    ready       = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    ready_found = 1'b0;
    ready_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = busy_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
      if (!busy_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (ready[i] && !ready_found) begin
        ready_found = 1'b1;
        ready_idx   = IDX_W'(i);
      end
    end
    sel_idx = lock_q ? lock_idx_q : ready_idx;
  end

  // Selection looks only at registered state, so a CDB capture issues one cycle later.
  assign DISP_READY     = free_found;
  assign ISSUE_VALID    = lock_q || ready_found;
  assign disp_fire      = DISP_VALID && free_found && !FLUSH;
  assign issue_fire     = ISSUE_VALID && ISSUE_READY && !FLUSH;
  assign ISSUE_OP       = ISSUE_VALID ? op_q[sel_idx]   : '0;
  assign ISSUE_DEST_TAG = ISSUE_VALID ? dest_q[sel_idx] : '0;
  assign ISSUE_VJ       = ISSUE_VALID ? vj_q[sel_idx]   : '0;
  assign ISSUE_VK       = ISSUE_VALID ? vk_q[sel_idx]   : '0;
  assign COUNT          = count_q;

  always_comb begin
    busy_d     = busy_q;
    op_d       = op_q;
    dest_d     = dest_q;
    qj_d       = qj_q;
    qk_d       = qk_q;
    vj_d       = vj_q;
    vk_d       = vk_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    count_d    = '0;
    if (FLUSH) begin
      busy_d = '0;
      lock_d = 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy_q[i] && cdb_hit) begin
          if (qj_q[i] == cdb_tag) begin
            qj_d[i] = '0;
            vj_d[i] = cdb_data;
          end
          if (qk_q[i] == cdb_tag) begin
            qk_d[i] = '0;
            vk_d[i] = cdb_data;
          end
        end
      end
      if (issue_fire) busy_d[sel_idx] = 1'b0;
      lock_d     = ISSUE_VALID && !ISSUE_READY;
      lock_idx_d = sel_idx;
      // The free slot is never the issuing slot, so dispatch and issue cannot collide.
      if (disp_fire) begin
        busy_d[free_idx] = 1'b1;
        op_d[free_idx]   = DISP_OP;
        dest_d[free_idx] = DISP_DEST_TAG;
        if (cdb_hit && (DISP_QJ == cdb_tag)) begin
          qj_d[free_idx] = '0;
          vj_d[free_idx] = cdb_data;
        end else begin
          qj_d[free_idx] = DISP_QJ;
          vj_d[free_idx] = DISP_VJ;
        end
        if (cdb_hit && (DISP_QK == cdb_tag)) begin
          qk_d[free_idx] = '0;
          vk_d[free_idx] = cdb_data;
        end else begin
          qk_d[free_idx] = DISP_QK;
          vk_d[free_idx] = DISP_VK;
        end
      end
    end
    for (int i = 0; i < DEPTH; i++) count_d = count_d + {2'b00, busy_d[i]};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      busy_q     <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]   <= '0;
        dest_q[i] <= '0;
        qj_q[i]   <= '0;
        qk_q[i]   <= '0;
        vj_q[i]   <= '0;
        vk_q[i]   <= '0;
      end
    end else begin
      busy_q     <= busy_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      count_q    <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]   <= op_d[i];
        dest_q[i] <= dest_d[i];
        qj_q[i]   <= qj_d[i];
        qk_q[i]   <= qk_d[i];
        vj_q[i]   <= vj_d[i];
        vk_q[i]   <= vk_d[i];
      end
    end
  end
endmodule

// File: tb/tb_cdb_reservation_station.sv
// Bench for cdb_reservation_station: directed vectors plus a short mixed-traffic run,
// all outputs compared every cycle against an entry-table model, with literal pins.
module tb_cdb_reservation_station;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int OP_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush, disp_valid, disp_ready, issue_valid, issue_ready;
  logic [OP_W-1:0]   disp_op, issue_op;
  logic [TAG_W-1:0]  disp_dest, disp_qj, disp_qk, issue_dest;
  logic [31:0]       disp_vj, disp_vk, issue_vj, issue_vk;
  logic [TAG_W+31:0] cdb_in;
  logic [2:0]        count;

  always #5 clk = ~clk;

  cdb_reservation_station #(.DEPTH(DEPTH), .TAG_W(TAG_W), .OP_W(OP_W)) dut (
    .CLK(clk), .RST_N(rst_n), .FLUSH(flush),
    .DISP_VALID(disp_valid), .DISP_READY(disp_ready), .DISP_OP(disp_op),
    .DISP_DEST_TAG(disp_dest), .DISP_QJ(disp_qj), .DISP_QK(disp_qk),
    .DISP_VJ(disp_vj), .DISP_VK(disp_vk), .CDB_IN(cdb_in),
    .ISSUE_VALID(issue_valid), .ISSUE_READY(issue_ready), .ISSUE_OP(issue_op),
    .ISSUE_DEST_TAG(issue_dest), .ISSUE_VJ(issue_vj), .ISSUE_VK(issue_vk),
    .COUNT(count)
  );

  int n_vec = 0;
  int n_err = 0;
  bit done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit               busy;
    logic [OP_W-1:0]  op;
    logic [TAG_W-1:0] dest, qj, qk;
    logic [31:0]      vj, vk;
  } ent_t;

  ent_t m[DEPTH];
  bit   m_lock;
  int   m_lock_idx;

  function automatic void m_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m[i].busy = 1'b0; m[i].op = '0; m[i].dest = '0;
      m[i].qj = '0; m[i].qk = '0; m[i].vj = '0; m[i].vk = '0;
    end
    m_lock = 1'b0;
    m_lock_idx = 0;
  endfunction

  function automatic int m_pick();
    if (m_lock) return m_lock_idx;
    for (int i = 0; i < DEPTH; i++)
      if (m[i].busy && m[i].qj == 0 && m[i].qk == 0) return i;
    return -1;
  endfunction

  function automatic int m_free();
    for (int i = 0; i < DEPTH; i++) if (!m[i].busy) return i;
    return -1;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) if (m[i].busy) c++;
    return c;
  endfunction

  function automatic void m_step();
    int p = m_pick();
    int f = m_free();
    logic [TAG_W-1:0] tag = cdb_in[TAG_W+31:32];
    logic [31:0] data = cdb_in[31:0];
    if (flush) begin
      m_reset();
      return;
    end
    if (tag != 0)
      for (int i = 0; i < DEPTH; i++)
        if (m[i].busy) begin
          if (m[i].qj == tag) begin m[i].qj = 0; m[i].vj = data; end
          if (m[i].qk == tag) begin m[i].qk = 0; m[i].vk = data; end
        end
    if (p >= 0) begin
      if (issue_ready) begin m[p].busy = 1'b0; m_lock = 1'b0; end
      else begin m_lock = 1'b1; m_lock_idx = p; end
    end else m_lock = 1'b0;
    if (disp_valid && f >= 0) begin
      m[f].busy = 1'b1;
      m[f].op   = disp_op;
      m[f].dest = disp_dest;
      if (tag != 0 && disp_qj == tag) begin m[f].qj = 0; m[f].vj = data; end
      else begin m[f].qj = disp_qj; m[f].vj = disp_vj; end
      if (tag != 0 && disp_qk == tag) begin m[f].qk = 0; m[f].vk = data; end
      else begin m[f].qk = disp_qk; m[f].vk = disp_vk; end
    end
  endfunction

  initial m_reset();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else m_step();
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    int p;
    logic [31:0] e_op, e_dest, e_vj, e_vk;
    if (!done) begin
      p = m_pick();
      e_op = 0; e_dest = 0; e_vj = 0; e_vk = 0;
      if (p >= 0) begin
        e_op = 32'(m[p].op); e_dest = 32'(m[p].dest); e_vj = m[p].vj; e_vk = m[p].vk;
      end
      check("disp_ready", 32'(disp_ready), (m_free() >= 0) ? 32'd1 : 32'd0);
      check("issue_valid", 32'(issue_valid), (p >= 0) ? 32'd1 : 32'd0);
      check("issue_op", 32'(issue_op), e_op);
      check("issue_dest", 32'(issue_dest), e_dest);
      check("issue_vj", issue_vj, e_vj);
      check("issue_vk", issue_vk, e_vk);
      check("count", 32'(count), 32'(m_count()));
    end
  end

  // ---------------- driver ----------------
  task automatic clr_in();
    flush = 1'b0; disp_valid = 1'b0; disp_op = '0; disp_dest = '0;
    disp_qj = '0; disp_qk = '0; disp_vj = '0; disp_vk = '0; cdb_in = '0;
  endtask

  task automatic disp(input logic [3:0] op, input logic [3:0] dest, input logic [3:0] qj,
                      input logic [31:0] vj, input logic [3:0] qk, input logic [31:0] vk);
    disp_valid = 1'b1; disp_op = op; disp_dest = dest;
    disp_qj = qj; disp_vj = vj; disp_qk = qk; disp_vk = vk;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] data);
    cdb_in = {tag, data};
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    clr_in();
    issue_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_disp_ready", 32'(disp_ready), 32'd1);
    check("rst_issue_valid", 32'(issue_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    rst_n = 1'b1;

    // Single ready dispatch flows straight to issue.
    issue_ready = 1'b1;
    disp(4'd3, 4'd5, 4'd0, 32'd10, 4'd0, 32'd20);
    tick();
    check("a_valid", 32'(issue_valid), 32'd1);
    check("a_vj", issue_vj, 32'd10);
    check("a_vk", issue_vk, 32'd20);
    check("a_dest", 32'(issue_dest), 32'd5);
    check("a_count1", 32'(count), 32'd1);
    clr_in();
    tick();
    check("a_count0", 32'(count), 32'd0);

    // Both operands wait on tag 7, one broadcast wakes both.
    issue_ready = 1'b0;
    disp(4'd1, 4'd2, 4'd7, 32'h0, 4'd7, 32'h0);
    tick();
    clr_in();
    cdb(4'd7, 32'hDEAD);
    #1 check("b_no_comb_path", 32'(issue_valid), 32'd0);
    tick();
    check("b_valid", 32'(issue_valid), 32'd1);
    check("b_vj", issue_vj, 32'hDEAD);
    check("b_vk", issue_vk, 32'hDEAD);
    clr_in();
    issue_ready = 1'b1;
    tick();

    // Same-cycle bypass, then a tag-0 broadcast must not disturb anything.
    issue_ready = 1'b0;
    disp(4'd4, 4'd1, 4'd9, 32'h1111, 4'd0, 32'h66);
    cdb(4'd9, 32'h55);
    tick();
    check("c_bypass_vj", issue_vj, 32'h55);
    clr_in();
    cdb(4'd0, 32'h77);
    tick();
    check("c_tag0_vj", issue_vj, 32'h55);
    check("c_tag0_vk", issue_vk, 32'h66);
    clr_in();
    issue_ready = 1'b1;
    tick();

    // Fill all entries, then dispatch while full alongside an issue.
    issue_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      disp(4'(i + 1), 4'd3, 4'd0, 32'((i + 1) * 100), 4'd0, 32'd1);
      tick();
    end
    check("d_full_ready", 32'(disp_ready), 32'd0);
    check("d_full_count", 32'(count), 32'd4);
    disp(4'd9, 4'd3, 4'd0, 32'd9, 4'd0, 32'd9);
    issue_ready = 1'b1;
    tick();
    check("d_count3", 32'(count), 32'd3);
    check("d_ready_again", 32'(disp_ready), 32'd1);
    check("d_next_op", 32'(issue_op), 32'd2);
    disp(4'd10, 4'd3, 4'd0, 32'd7, 4'd0, 32'd7);
    tick();
    check("d_disp_issue_count", 32'(count), 32'd3);
    check("d_refill_op", 32'(issue_op), 32'd10);
    clr_in();
    repeat (3) tick();
    check("d_drained", 32'(count), 32'd0);

    // Stalled entry 2 stays locked while entry 0 becomes ready.
    issue_ready = 1'b0;
    disp(4'd5, 4'd1, 4'hA, 32'h0, 4'd0, 32'h3);
    tick();
    disp(4'd6, 4'd1, 4'hB, 32'h0, 4'd0, 32'h4);
    tick();
    disp(4'd7, 4'd8, 4'd0, 32'h222, 4'd0, 32'h333);
    tick();
    check("e_present2", 32'(issue_op), 32'd7);
    clr_in();
    cdb(4'hA, 32'h1234);
    tick();
    clr_in();
    check("e_locked_op", 32'(issue_op), 32'd7);
    check("e_locked_vj", issue_vj, 32'h222);
    tick();
    check("e_still_locked", 32'(issue_dest), 32'd8);
    issue_ready = 1'b1;
    tick();
    check("e_then_entry0", 32'(issue_op), 32'd5);
    check("e_entry0_vj", issue_vj, 32'h1234);
    tick();
    check("e_count1", 32'(count), 32'd1);

    // Flush drops a concurrent dispatch; reset pulse mid-stream.
    issue_ready = 1'b0;
    disp(4'd2, 4'd1, 4'hC, 32'h0, 4'd0, 32'h0);
    tick();
    tick();
    check("f_three_busy", 32'(count), 32'd3);
    disp(4'd3, 4'd3, 4'd0, 32'h5, 4'd0, 32'h6);
    flush = 1'b1;
    tick();
    check("f_count", 32'(count), 32'd0);
    check("f_valid", 32'(issue_valid), 32'd0);
    flush = 1'b0;
    disp(4'd6, 4'd2, 4'd0, 32'h60, 4'd0, 32'h61);
    tick();
    tick();
    check("f_pre_rst_count", 32'(count), 32'd2);
    #3 rst_n = 1'b0;
    #1;
    check("r_count", 32'(count), 32'd0);
    check("r_valid", 32'(issue_valid), 32'd0);
    check("r_op", 32'(issue_op), 32'd0);
    check("r_vj", issue_vj, 32'd0);
    check("r_disp_ready", 32'(disp_ready), 32'd1);
    clr_in();
    tick();
    rst_n = 1'b1;
    issue_ready = 1'b1;
    disp(4'd2, 4'd0, 4'd0, 32'h42, 4'd0, 32'h43);
    tick();
    check("r_first_disp", 32'(count), 32'd1);
    check("r_first_vj", issue_vj, 32'h42);
    check("r_invalid_dest", 32'(issue_dest), 32'd0);
    clr_in();
    tick();

    // Mixed traffic over a small tag space, checked by the model each cycle.
    for (int c = 0; c < 120; c++) begin
      clr_in();
      if ($urandom_range(0, 2) != 0)
        disp(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
             $urandom, 4'($urandom_range(0, 3)), $urandom);
      cdb(4'($urandom_range(0, 3)), $urandom);
      issue_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 29) == 0);
      tick();
    end
    clr_in();
    flush = 1'b1;
    tick();
    clr_in();
    tick();

    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
